image_memory_stream: RTL and testbench

IMAGE_MEMORY_STREAM -- requirements
Module: image_memory_stream

---
 rtl/image_memory_stream.sv | 127 ++++++++++++
 tb/tb_image_memory_stream.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/image_memory_stream.sv
// Pixel memory with a registered processor read/write port and an independent
// read port that streams a base/length window as a valid/ready pixel stream.
`default_nettype none

module image_memory_stream #(
    parameter int    DATA_W    = 8,
    parameter int    DEPTH     = 40000,
    parameter int    ADDR_W    = 18,
    parameter string INIT_PATH = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    output logic [DATA_W-1:0] s_data,
    output logic              s_valid,
    input  logic              s_ready,
    output logic              s_last,
    output logic              busy,
    output logic              done
);

    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] count;
    logic              a_in_range;
    logic              base_in_range;

    assign a_in_range    = {1'b0, a} < DEPTH_EXT;
    assign base_in_range = {1'b0, base} < DEPTH_EXT;
    assign busy          = (state == FETCH) || (state == SEND);
    assign done          = (state == DONE);

    // Memory is deliberately outside the reset domain so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we && a_in_range) begin
            mem[a[IDX_W-1:0]] <= wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd <= '0;
        end else if (!we) begin
            rd <= a_in_range ? mem[a[IDX_W-1:0]] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // s_last is registered as "this is beat len-1", so it doubles as the exit test.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = (len == '0) ? DONE : FETCH;
            FETCH:   state_next = SEND;
            SEND:    if (s_ready) state_next = s_last ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr <= '0;
            len_r    <= '0;
            count    <= '0;
            s_data   <= '0;
            s_valid  <= 1'b0;
            s_last   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        cur_addr <= base_in_range ? base : '0;
                        len_r    <= len;
                        count    <= '0;
                    end
                end
                FETCH: begin
                    s_data  <= mem[cur_addr[IDX_W-1:0]];
                    s_valid <= 1'b1;
                    s_last  <= (count == len_r - 1'b1);
                end
                SEND: begin
                    if (s_ready) begin
                        s_valid <= 1'b0;
                        s_last  <= 1'b0;
                        if (!s_last) begin
                            count    <= count + 1'b1;
                            cur_addr <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_image_memory_stream.sv
// Scoreboard bench for image_memory_stream: stimulus pushes expected beats,
// a negedge monitor pops and compares them against the stream output.
`default_nettype none

module tb_image_memory_stream;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 40000;
    localparam int ADDR_W = 18;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] a = '0;
    logic [DATA_W-1:0] wd = '0;
    logic [DATA_W-1:0] rd;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base = '0;
    logic [ADDR_W-1:0] len = '0;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready = 1'b0;
    logic              s_last;
    logic              busy;
    logic              done;

    image_memory_stream #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_PATH("")
    ) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .a(a), .wd(wd), .rd(rd),
        .start(start), .base(base), .len(len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              last;
    } beat_t;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] model_mem [DEPTH];
    int                tests = 0;
    int                fails = 0;
    int                beats_done = 0;
    bit                rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: beats checked against the queue, held beats checked for stability.
    initial begin : monitor
        logic              pv, pr, pl;
        logic [DATA_W-1:0] pd;
        beat_t             e;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (rst_n && pv && !pr) begin
                check("stall_valid_held", s_valid, 1);
                check("stall_data_stable", s_data, pd);
                check("stall_last_stable", s_last, pl);
            end
            if (rst_n && s_valid && s_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", s_data, e.d);
                    check("beat_last", s_last, e.last);
                    beats_done++;
                end
            end
            pv = rst_n && s_valid;
            pr = s_ready;
            pd = s_data;
            pl = s_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) s_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wr(input int addr, input logic [DATA_W-1:0] data);
        we = 1'b1; a = ADDR_W'(addr); wd = data;
        tick();
        we = 1'b0;
        if (addr < DEPTH) model_mem[addr] = data;
    endtask

    task automatic rd_check(input int addr, input string name);
        we = 1'b0; a = ADDR_W'(addr);
        tick();
        check(name, rd, (addr < DEPTH) ? model_mem[addr] : 8'h00);
    endtask

    task automatic run_stream(input int b, input int n, input bit lat_check,
                              input bit stall, input bit busy_start);
        int addr, cyc, stall_left;
        addr = (b < DEPTH) ? b : 0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({model_mem[addr], (i == n - 1)});
            addr = (addr + 1) % DEPTH;
        end
        beats_done = 0;
        stall_left = stall ? 4 : 0;
        start = 1'b1; base = ADDR_W'(b); len = ADDR_W'(n);
        tick();
        start = 1'b0;
        cyc = 2;
        if (n > 0) check("busy_during_stream", busy, 1);
        while (!done) begin
            if (cyc > 2000) begin
                check("done_timeout", 0, 1);
                break;
            end
            start = busy_start && (cyc == 2);
            base  = '0;
            len   = ADDR_W'(1);
            tick();
            cyc++;
            if (stall) begin
                if (beats_done == 1 && stall_left > 0) begin
                    s_ready = 1'b0;
                    stall_left--;
                end else begin
                    s_ready = 1'b1;
                end
            end
        end
        start = 1'b0;
        if (lat_check) check("done_latency", cyc, 2 * n + 2);
        check("beats_outstanding", exp_q.size(), 0);
        tick();
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
    endtask

    function automatic int win_addr();
        int r;
        r = $urandom_range(0, 31);
        return (r < 16) ? r : DEPTH - 32 + r;
    endfunction

    initial begin : stimulus
        int op, b, n;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        repeat (2) tick();
        check("rst_rd", rd, 0);
        check("rst_s_data", s_data, 0);
        check("rst_s_valid", s_valid, 0);
        check("rst_s_last", s_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        wr(5, 8'hA5);
        rd_check(5, "proc_read_a5");
        wr(7, 8'h3C);
        check("rd_held_on_write", rd, 8'hA5);
        wr(DEPTH, 8'h5A);
        rd_check(DEPTH, "proc_read_out_of_range");
        rd_check(7, "proc_read_7");

        for (int i = 0; i < 4; i++) wr(10 + i, DATA_W'(i + 1));
        s_ready = 1'b1;
        run_stream(10, 4, 1'b1, 1'b0, 1'b0);
        run_stream(10, 4, 1'b0, 1'b1, 1'b0);
        s_ready = 1'b1;

        wr(DEPTH - 2, 8'h11); wr(DEPTH - 1, 8'h22); wr(0, 8'h33); wr(1, 8'h44);
        run_stream(DEPTH - 2, 4, 1'b1, 1'b0, 1'b0);
        run_stream(0, 0, 1'b1, 1'b0, 1'b0);
        run_stream(10, 4, 1'b1, 1'b0, 1'b1);
        run_stream(DEPTH + 3, 2, 1'b1, 1'b0, 1'b0);

        // Reset in the SEND cycle of beat 2.
        for (int i = 0; i < 4; i++) exp_q.push_back({DATA_W'(i + 1), (i == 3)});
        a = ADDR_W'(10); we = 1'b0; s_ready = 1'b1;
        start = 1'b1; base = ADDR_W'(10); len = ADDR_W'(4);
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2;
        check("pre_reset_valid", s_valid, 1);
        check("pre_reset_rd", rd, 1);
        rst_n = 1'b0;
        #1;
        check("reset_s_valid", s_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_rd", rd, 0);
        check("reset_s_last", s_last, 0);
        exp_q.delete();
        repeat (2) begin
            tick();
            check("reset_no_done", done, 0);
        end
        rst_n = 1'b1;
        tick();
        check("post_reset_done", done, 0);
        for (int i = 0; i < 4; i++) rd_check(10 + i, "mem_retained");

        for (int r = 0; r < 32; r++) wr((r < 16) ? r : DEPTH - 32 + r, DATA_W'($urandom));
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                wr(win_addr(), DATA_W'($urandom));
            end else if (op == 1) begin
                rd_check(win_addr(), "rand_read");
            end else begin
                b = ($urandom_range(0, 7) == 0) ? DEPTH + $urandom_range(0, 100) : win_addr();
                if (b < 16) b = $urandom_range(0, 8);
                n = $urandom_range(0, 8);
                run_stream(b, n, 1'b0, 1'b0, ($urandom_range(0, 3) == 0));
            end
        end
        rand_ready = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
